// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register word indices,
// slave FSM states and the default pin count.
package gpio_pkg;

  localparam int NUM_GPIO_DEF = 8;

  // Word index taken from PADDR[4:2]
  localparam logic [2:0] REG_MODER = 3'd0;
  localparam logic [2:0] REG_ODR   = 3'd1;
  localparam logic [2:0] REG_IDR   = 3'd2;
  localparam logic [2:0] REG_IER   = 3'd3;
  localparam logic [2:0] REG_ISR   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchronizer plus one delay stage used to detect rising
// edges on each synchronized pin.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int NUM_GPIO = NUM_GPIO_DEF
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] sync_out,
  output logic [NUM_GPIO-1:0] rise
);

  logic [NUM_GPIO-1:0] sync_p0;
  logic [NUM_GPIO-1:0] sync_p1;
  logic [NUM_GPIO-1:0] sync_p2;

  // p0/p1 resolve metastability, p2 is p1 delayed for edge detection
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= gpio_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign sync_out = sync_p1;
  assign rise     = sync_p1 & ~sync_p2;

endmodule

// File: rtl/apb_gpio.sv
// APB slave GPIO block: direction/output/input/interrupt registers behind a
// one-wait-state APB interface, with sticky rising-edge interrupt status.
module apb_gpio
  import gpio_pkg::*;
#(
  parameter int NUM_GPIO = NUM_GPIO_DEF
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [11:0]         PADDR,
  input  logic                PWRITE,
  input  logic                PENABLE,
  input  logic                PSEL,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  apb_state_e          state;
  logic [NUM_GPIO-1:0] moder;
  logic [NUM_GPIO-1:0] odr;
  logic [NUM_GPIO-1:0] ier;
  logic [NUM_GPIO-1:0] isr;
  logic [NUM_GPIO-1:0] idr;
  logic [NUM_GPIO-1:0] rise;
  logic [NUM_GPIO-1:0] isr_clr;
  logic [31:0]         rdata;
  logic [2:0]          reg_sel;
  logic                wr_en;
  logic                unused_bits;

  gpio_sync_edge #(.NUM_GPIO(NUM_GPIO)) u_sync_edge (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .gpio_in  (gpio_in),
    .sync_out (idr),
    .rise     (rise)
  );

  assign reg_sel     = PADDR[4:2];
  assign unused_bits = ^{PADDR, PWDATA};

  // PREADY is registered alongside the state so it is high exactly in DONE
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= ST_IDLE;
      PREADY <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          PREADY <= 1'b0;
          if (PSEL && PENABLE) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (PSEL) begin
            state  <= ST_DONE;
            PREADY <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            PREADY <= 1'b0;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          PREADY <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          PREADY <= 1'b0;
        end
      endcase
    end
  end

  // The write lands on the edge that closes the PREADY cycle
  assign wr_en   = (state == ST_DONE) && PSEL && PWRITE;
  assign isr_clr = (wr_en && reg_sel == REG_ISR) ? PWDATA[NUM_GPIO-1:0] : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      moder <= '0;
      odr   <= '0;
      ier   <= '0;
      isr   <= '0;
    end else begin
      if (wr_en && reg_sel == REG_MODER) moder <= PWDATA[NUM_GPIO-1:0];
      if (wr_en && reg_sel == REG_ODR)   odr   <= PWDATA[NUM_GPIO-1:0];
      if (wr_en && reg_sel == REG_IER)   ier   <= PWDATA[NUM_GPIO-1:0];
      // Set wins over a simultaneous write-1-to-clear
      isr <= (isr & ~isr_clr) | (rise & ier);
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_MODER: rdata[NUM_GPIO-1:0] = moder;
      REG_ODR:   rdata[NUM_GPIO-1:0] = odr;
      REG_IDR:   rdata[NUM_GPIO-1:0] = idr;
      REG_IER:   rdata[NUM_GPIO-1:0] = ier;
      REG_ISR:   rdata[NUM_GPIO-1:0] = isr;
      default:   rdata = '0;
    endcase
  end

  assign PRDATA   = PREADY ? rdata : 32'h0;
  assign gpio_oe  = moder;
  assign gpio_out = odr & moder;
  assign irq      = |isr;

endmodule

// File: tb/tb_apb_gpio.sv
// Directed bench for apb_gpio: APB access timing, register behaviour,
// input synchronization, interrupts and reset.
module tb_apb_gpio;

  logic        PCLK;
  logic        PRESET;
  logic [11:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  int          ed;
  logic        seen_ready;

  apb_gpio #(.NUM_GPIO(8)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge. chg_phase selects when
  // gpio_in is changed: 0 with SETUP, 1 with PENABLE, 2 after the first
  // ACCESS edge, anything else never.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input int chg_phase, input logic [7:0] chg_val);
    ed = 0;
    rd = '0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    if (chg_phase == 0) gpio_in = chg_val;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (chg_phase == 1) gpio_in = chg_val;
    do begin
      @(posedge PCLK); ed++; #1;
      if (ed == 1 && chg_phase == 2) gpio_in = chg_val;
    end while (!PREADY && ed < 8);
    if (PREADY) rd = PRDATA;
    else chk("pready_timeout", {31'b0, PREADY}, 32'h1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data);
    apb_xfer(1'b1, addr, data, -1, 8'h00);
  endtask

  task automatic rd_reg(input logic [11:0] addr);
    apb_xfer(1'b0, addr, 32'h0, -1, 8'h00);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpio_in = 8'h00;
    cycles(3);
    chk("rst_pready", {31'b0, PREADY}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_oe", {24'b0, gpio_oe}, 32'h0);
    chk("rst_out", {24'b0, gpio_out}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    PRESET = 1'b0;
    cycles(2);

    // Write then read with all pins as outputs
    wr_reg(12'h000, 32'h0000_00FF);
    chk("wr_edges", ed, 2);
    wr_reg(12'h004, 32'h0000_00A5);
    chk("out_a5", {24'b0, gpio_out}, 32'hA5);
    rd_reg(12'h004);
    chk("rd_odr", rd, 32'h0000_00A5);
    chk("rd_edges", ed, 2);
    chk("prdata_idle", PRDATA, 32'h0);

    // MODER masks ODR; upper write bits are dropped
    wr_reg(12'h000, 32'hFFFF_FF0F);
    wr_reg(12'h004, 32'h0000_00FF);
    chk("mask_out", {24'b0, gpio_out}, 32'h0F);
    chk("mask_oe", {24'b0, gpio_oe}, 32'h0F);
    rd_reg(12'h000);
    chk("rd_moder_upper0", rd, 32'h0000_000F);

    // Input latency: one edge is not enough, two are
    apb_xfer(1'b0, 12'h008, 32'h0, 2, 8'h81);
    chk("idr_1cyc", rd, 32'h0);
    rd_reg(12'h008);
    chk("idr_settled", rd, 32'h81);
    apb_xfer(1'b0, 12'h008, 32'h0, 1, 8'h00);
    chk("idr_2cyc", rd, 32'h0);

    // Rising edge on an enabled pin sets ISR three edges later
    wr_reg(12'h00C, 32'h0000_0001);
    cycles(3);
    gpio_in = 8'h01;
    cycles(2);
    chk("irq_2cyc", {31'b0, irq}, 32'h0);
    cycles(1);
    chk("irq_3cyc", {31'b0, irq}, 32'h1);
    rd_reg(12'h010);
    chk("isr_set", rd, 32'h01);
    wr_reg(12'h010, 32'h0000_0001);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    gpio_in = 8'h03;
    cycles(4);
    rd_reg(12'h010);
    chk("isr_masked", rd, 32'h0);

    // Set and clear of ISR[0] on the same edge
    gpio_in = 8'h00;
    cycles(4);
    gpio_in = 8'h01;
    cycles(4);
    chk("pre_collide_irq", {31'b0, irq}, 32'h1);
    gpio_in = 8'h00;
    cycles(4);
    apb_xfer(1'b1, 12'h010, 32'h0000_0001, 1, 8'h01);
    rd_reg(12'h010);
    chk("collide_isr", rd, 32'h01);
    chk("collide_irq", {31'b0, irq}, 32'h1);

    // Reset asserted while the slave sits in WAIT
    gpio_in = 8'h00;
    cycles(4);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h004;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("wait_pready", {31'b0, PREADY}, 32'h0);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_pready", {31'b0, PREADY}, 32'h0);
    chk("mid_rst_prdata", PRDATA, 32'h0);
    chk("mid_rst_oe", {24'b0, gpio_oe}, 32'h0);
    chk("mid_rst_out", {24'b0, gpio_out}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    cycles(2);
    rd_reg(12'h000);
    chk("post_rst_moder", rd, 32'h0);
    rd_reg(12'h004);
    chk("post_rst_odr", rd, 32'h0);
    rd_reg(12'h00C);
    chk("post_rst_ier", rd, 32'h0);
    rd_reg(12'h010);
    chk("post_rst_isr", rd, 32'h0);

    // Unmapped offsets and IDR ignore writes and read zero
    wr_reg(12'h000, 32'h0000_00FF);
    wr_reg(12'h01C, 32'h0000_0055);
    rd_reg(12'h01C);
    chk("unmapped_rd", rd, 32'h0);
    chk("unmapped_edges", ed, 2);
    rd_reg(12'h000);
    chk("unmapped_wr_ignored", rd, 32'hFF);
    wr_reg(12'h008, 32'h0000_00FF);
    rd_reg(12'h008);
    chk("idr_ro", rd, 32'h0);

    // PSEL dropped while in WAIT: no PREADY, FSM recovers
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h000;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      seen_ready = seen_ready | PREADY;
    end
    chk("abort_no_pready", {31'b0, seen_ready}, 32'h0);
    rd_reg(12'h000);
    chk("abort_recover", rd, 32'hFF);
    chk("abort_recover_edges", ed, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
